instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Holds the program counter and fetches one instruction at a time over a valid/ready instruction-memory interface. It presents the fetched word to the decode stage: the opcode, func3 and func7 fields feed the control-signal decoder. When an instruction retires, it computes the next PC from the decoder's 2-bit pc_src and the execute-stage target and taken inputs. It is the stage directly upstream of control decode and closes the PC loop for the single-issue core.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  XLEN  fetch address (= pc)
imem_rsp_valid  in  1  response data valid
imem_rsp_data  in  32  fetched instruction word
instr_valid  out  1  instr/instr_pc valid to decode
instr_ready  in  1  downstream retires the held instruction this cycle
instr  out  32  held instruction word
instr_pc  out  XLEN  PC of held instruction
pc_src  in  2  00 plus4, 01 branch, 10 JAL, 11 JALR (sampled at retire)
branch_taken  in  1  branch condition true (sampled at retire)
target_addr  in  XLEN  branch/JAL/JALR target from execute
fetch_fault  out  1  sticky misaligned-target flag
retired_count  out  32  number of retired instructions

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, state=REQ, instr=32'h0000_0013 (NOP), instr_pc=0, instr_valid=0, imem_req_valid=0, fetch_fault=0, retired_count=0. The first request is asserted in the first cycle after reset release.
- FSM states: REQ, WAIT, HOLD, HALT.
- REQ: imem_req_valid=1, imem_addr=pc, both held stable until imem_req_ready=1. On ready, go to WAIT.
- WAIT: request deasserted. When imem_rsp_valid=1, register imem_rsp_data into instr and pc into instr_pc, set instr_valid=1, go to HOLD. A response in the same cycle as the request handshake is not accepted; the response arrives at least 1 cycle after the request.
- HOLD: instr_valid=1; instr and instr_pc are stable. When instr_ready=1 (retire):
  - retired_count increments by 1, wrapping at 2^32.
  - next_pc is chosen by pc_src:
    - 00: pc+4
    - 01: target_addr if branch_taken, else pc+4
    - 10: target_addr
    - 11: target_addr with bit 0 cleared
  - If next_pc[1:0]!=0: fetch_fault=1, instr_valid=0, go to HALT, pc unchanged.
  - Otherwise: pc=next_pc, instr_valid=0, go to REQ.
- HALT: no requests, instr_valid=0, fetch_fault stays 1. Only reset exits HALT.
- Single outstanding request. Minimum loop is REQ→WAIT→HOLD→REQ, 3 cycles per instruction with a zero-wait memory. instr_valid falls the cycle after retire.
- pc+4 wraps modulo 2^XLEN with no fault.
- imem_rsp_valid outside WAIT is ignored.
- instr_ready outside HOLD is ignored, and the next-PC inputs are not sampled.
- Reset asserted mid-transaction (REQ/WAIT/HOLD) aborts it immediately. No retire is counted and no response is captured.

Decomposition:
- Shared package holds:
  - pc_src encodings (PC_PLUS4=2'b00, PC_BRANCH=2'b01, PC_JAL=2'b10, PC_JALR=2'b11), identical to the decoder's encoding.
  - FSM state encoding.
  - NOP constant 32'h0000_0013.
  - RESET_PC default.
- One combinational sub-module, next_pc_calc (inputs pc, pc_src, branch_taken, target_addr; outputs next_pc, misaligned). It is reusable by a later pipelined fetch.

Test Plan:
- Reset release with zero-wait memory returning 32'h0000_0013 at every address, instr_ready=1 on each HOLD → addresses 0x0, 0x4, 0x8 are requested; instr_valid pulses every 3rd cycle; retired_count=3 after 3 retires.
- Hold imem_req_ready=0 for 4 cycles → imem_req_valid stays 1 and imem_addr stays stable; no state advance. Delay the response 5 cycles → instr_valid stays 0 throughout.
- Retire at pc=0x10 with pc_src=01 and target 0x40: branch_taken=1 → next fetch 0x40; branch_taken=0 → next fetch 0x14.
- Retire with pc_src=11 and target 0x0000_0101 → next fetch 0x100. Retire with pc_src=10 and target 0x0000_0102 → fetch_fault=1, HALT, no further imem_req_valid.
- Hold instr_ready=0 for 10 cycles in HOLD → instr and instr_pc unchanged, no new request, retired_count constant.
- Assert rst_n low while in WAIT, then pulse imem_rsp_valid → response ignored, all outputs at reset values; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC source
// encodings (shared with the control decoder), FSM states and constants.
package instr_fetch_unit_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;   // addi x0, x0, 0

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JAL    = 2'b10,
      PC_JALR   = 2'b11
   } pc_src_e;

   typedef enum logic [1:0] {
      ST_REQ  = 2'b00,
      ST_WAIT = 2'b01,
      ST_HOLD = 2'b10,
      ST_HALT = 2'b11
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus. The fetch unit is the master,
// the memory (or its model) is the slave.
interface instr_fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Purely combinational next-PC selection and alignment check. Kept free of
// state so a pipelined fetch can reuse it unchanged.
module next_pc_calc
   import instr_fetch_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      pc_src,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] target_addr,
   output logic [XLEN-1:0] next_pc,
   output logic            misaligned
);

   logic [XLEN-1:0] pc_plus4;

   // Sequential address wraps naturally modulo 2^XLEN.
   assign pc_plus4 = pc + XLEN'(4);

   // Select the successor PC from the decoder's pc_src encoding.
   always_comb begin
      next_pc = pc_plus4;
      case (pc_src_e'(pc_src))
         PC_PLUS4:  next_pc = pc_plus4;
         PC_BRANCH: next_pc = branch_taken ? target_addr : pc_plus4;
         PC_JAL:    next_pc = target_addr;
         PC_JALR:   next_pc = {target_addr[XLEN-1:1], 1'b0};
         default:   next_pc = pc_plus4;
      endcase
   end

   // No compressed instructions: any target not word aligned is a fault.
   assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter and single-outstanding instruction fetch. Requests one
// word at a time, holds it for decode and advances the PC on retire.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_unit_if.master imem,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [31:0]        instr,
   output logic [XLEN-1:0]    instr_pc,
   input  logic [1:0]         pc_src,
   input  logic               branch_taken,
   input  logic [XLEN-1:0]    target_addr,
   output logic               fetch_fault,
   output logic [31:0]        retired_count
);

   fetch_state_e    state_reg, state_next;
   logic [XLEN-1:0] pc_reg;
   logic [31:0]     instr_reg;
   logic [XLEN-1:0] instr_pc_reg;
   logic            instr_valid_reg;
   logic            req_valid_reg;
   logic            fault_reg;
   logic [31:0]     retired_reg;

   logic            capture_fire;
   logic            retire_fire;
   logic [XLEN-1:0] next_pc;
   logic            next_misaligned;

   next_pc_calc #(
      .XLEN (XLEN)
   ) u_next_pc_calc (
      .pc           (pc_reg),
      .pc_src       (pc_src),
      .branch_taken (branch_taken),
      .target_addr  (target_addr),
      .next_pc      (next_pc),
      .misaligned   (next_misaligned)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_REQ;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; capture/retire strobes are only raised in the one
   // state where the matching input is meaningful, so stray inputs elsewhere
   // have no effect.
   always_comb begin
      state_next   = state_reg;
      capture_fire = 1'b0;
      retire_fire  = 1'b0;
      case (state_reg)
         ST_REQ: begin
            // req_valid_reg gates the handshake so the reset cycle, where the
            // request is still low, cannot be mistaken for an accepted request.
            if (req_valid_reg && imem.imem_req_ready) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem.imem_rsp_valid) begin
               capture_fire = 1'b1;
               state_next   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (instr_ready) begin
               retire_fire = 1'b1;
               state_next  = next_misaligned ? ST_HALT : ST_REQ;
            end
         end
         ST_HALT: begin
            state_next = ST_HALT;
         end
         default: begin
            state_next = ST_HALT;
         end
      endcase
   end

   // Datapath: request strobe, instruction capture, PC update and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg          <= RESET_PC;
         instr_reg       <= NOP_INSTR;
         instr_pc_reg    <= '0;
         instr_valid_reg <= 1'b0;
         req_valid_reg   <= 1'b0;
         fault_reg       <= 1'b0;
         retired_reg     <= '0;
      end else begin
         // Registered so the request rises on the first edge after reset.
         req_valid_reg <= (state_next == ST_REQ);
         if (capture_fire) begin
            instr_reg       <= imem.imem_rsp_data;
            instr_pc_reg    <= pc_reg;
            instr_valid_reg <= 1'b1;
         end
         if (retire_fire) begin
            retired_reg     <= retired_reg + 32'd1;
            instr_valid_reg <= 1'b0;
            if (next_misaligned) begin
               fault_reg <= 1'b1;
            end else begin
               pc_reg <= next_pc;
            end
         end
      end
   end

   assign imem.imem_req_valid = req_valid_reg;
   assign imem.imem_addr      = pc_reg;
   assign instr_valid         = instr_valid_reg;
   assign instr               = instr_reg;
   assign instr_pc            = instr_pc_reg;
   assign fetch_fault         = fault_reg;
   assign retired_count       = retired_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit. The bench plays the
// memory and the downstream stage and tracks the expected PC, retire count
// and fault flag with a plain arithmetic model.
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [1:0]  pc_src;
   logic        branch_taken;
   logic [31:0] target_addr;
   logic        fetch_fault;
   logic [31:0] retired_count;

   instr_fetch_unit_if #(.XLEN(32)) bus ();

   instr_fetch_unit #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem          (bus),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .pc_src        (pc_src),
      .branch_taken  (branch_taken),
      .target_addr   (target_addr),
      .fetch_fault   (fetch_fault),
      .retired_count (retired_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] model_pc;
   logic [31:0] model_count;
   logic        model_fault;
   logic [31:0] model_instr;
   int unsigned valid_cyc;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
      check({tag, "_addr"}, bus.imem_addr, 32'h0);
      check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
      check({tag, "_instr"}, instr, NOP_INSTR);
      check({tag, "_instr_pc"}, instr_pc, 32'h0);
      check({tag, "_fault"}, 32'(fetch_fault), 32'd0);
      check({tag, "_count"}, retired_count, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst");
      for (int i = 0; i < 2; i++) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = $urandom;
         instr_ready        = 1'b1;
         tick();
      end
      bus.imem_rsp_valid = 1'b0;
      instr_ready        = 1'b0;
      check_reset_outputs("rst_hold");
      rst_n       = 1'b1;
      model_pc    = 32'h0;
      model_count = 32'h0;
      model_fault = 1'b0;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!bus.imem_req_valid && n < 20) begin
         tick();
         n++;
      end
      check("req_seen", 32'(bus.imem_req_valid), 32'd1);
   endtask

   task automatic fetch_one(input int rdly, input int sdly, input logic [31:0] word);
      wait_req();
      check("req_addr", bus.imem_addr, model_pc);
      for (int i = 0; i < rdly; i++) begin
         bus.imem_req_ready = 1'b0;
         tick();
         check("req_stall_valid", 32'(bus.imem_req_valid), 32'd1);
         check("req_stall_addr", bus.imem_addr, model_pc);
      end
      // A response in the handshake cycle must not be captured.
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = ~word;
      tick();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      check("req_drop", 32'(bus.imem_req_valid), 32'd0);
      for (int i = 0; i < sdly; i++) begin
         // Retire attempts while waiting must be ignored.
         instr_ready  = 1'($urandom);
         pc_src       = 2'($urandom);
         branch_taken = 1'($urandom);
         target_addr  = $urandom | 32'h1;
         tick();
         check("wait_instr_valid", 32'(instr_valid), 32'd0);
         check("wait_count", retired_count, model_count);
      end
      instr_ready        = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = word;
      tick();
      bus.imem_rsp_valid = 1'b0;
      model_instr = word;
      valid_cyc   = cyc;
      check("cap_valid", 32'(instr_valid), 32'd1);
      check("cap_instr", instr, word);
      check("cap_pc", instr_pc, model_pc);
   endtask

   task automatic retire(input int hold, input logic [1:0] src, input logic taken,
                         input logic [31:0] tgt);
      logic [31:0] nxt;
      for (int i = 0; i < hold; i++) begin
         instr_ready  = 1'b0;
         pc_src       = 2'($urandom);
         branch_taken = 1'($urandom);
         target_addr  = $urandom;
         tick();
         check("hold_valid", 32'(instr_valid), 32'd1);
         check("hold_instr", instr, model_instr);
         check("hold_pc", instr_pc, model_pc);
         check("hold_no_req", 32'(bus.imem_req_valid), 32'd0);
         check("hold_count", retired_count, model_count);
      end
      pc_src       = src;
      branch_taken = taken;
      target_addr  = tgt;
      instr_ready  = 1'b1;
      tick();
      instr_ready = 1'b0;
      case (src)
         2'd0:    nxt = model_pc + 32'd4;
         2'd1:    nxt = taken ? tgt : model_pc + 32'd4;
         2'd2:    nxt = tgt;
         default: nxt = tgt & 32'hFFFF_FFFE;
      endcase
      model_count = model_count + 32'd1;
      if (nxt[1:0] != 2'b00) model_fault = 1'b1;
      else model_pc = nxt;
      check("ret_valid_low", 32'(instr_valid), 32'd0);
      check("ret_fault", 32'(fetch_fault), 32'(model_fault));
      check("ret_count", retired_count, model_count);
   endtask

   initial begin
      int unsigned prev_cyc;
      logic [1:0]  rs;
      logic [31:0] rt;

      rst_n              = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      instr_ready        = 1'b0;
      pc_src             = 2'b00;
      branch_taken       = 1'b0;
      target_addr        = '0;
      tick();
      do_reset();
      check("post_release_req", 32'(bus.imem_req_valid), 32'd0);

      // Zero-wait memory, immediate retire: one instruction every 3 cycles.
      fetch_one(0, 0, NOP_INSTR);
      retire(0, 2'b00, 1'b0, 32'h0);
      for (int k = 0; k < 2; k++) begin
         prev_cyc = valid_cyc;
         fetch_one(0, 0, NOP_INSTR);
         check("loop_3cyc", valid_cyc - prev_cyc, 32'd3);
         retire(0, 2'b00, 1'b0, 32'h0);
      end
      check("three_retired", retired_count, 32'd3);

      // Request stall then slow response; pc 0xC -> 0x10.
      fetch_one(4, 5, 32'h0010_0093);
      retire(0, 2'b00, 1'b0, 32'h0);
      check("pc_at_10", model_pc, 32'h10);

      // Taken branch at 0x10 -> 0x40, back via JAL, not-taken -> 0x14.
      fetch_one(0, 1, 32'h0200_0863);
      retire(0, 2'b01, 1'b1, 32'h40);
      fetch_one(1, 0, 32'hFD1F_F06F);
      retire(0, 2'b10, 1'b0, 32'h10);
      fetch_one(0, 0, 32'h0200_0863);
      retire(0, 2'b01, 1'b0, 32'h40);

      // Long hold at 0x14, then JALR to 0x101 clears bit 0 -> 0x100.
      fetch_one(0, 2, 32'h0000_8067);
      retire(10, 2'b11, 1'b0, 32'h0000_0101);

      // Wrap: JAL to the top word, then plus4 wraps to 0 without fault.
      fetch_one(0, 0, 32'h1234_5678);
      retire(0, 2'b10, 1'b0, 32'hFFFF_FFFC);
      fetch_one(0, 0, 32'h8765_4321);
      retire(0, 2'b00, 1'b0, 32'h0);
      check("pc_wrapped", model_pc, 32'h0);

      // Randomized aligned traffic.
      for (int k = 0; k < 20; k++) begin
         rs = 2'($urandom_range(0, 3));
         rt = $urandom & 32'hFFFF_FFFC;
         if (rs == 2'b11) rt = rt | 32'($urandom_range(0, 1));
         fetch_one(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), $urandom);
         retire(int'($urandom_range(0, 3)), rs, 1'($urandom), rt);
      end

      // Misaligned JAL target: fault and halt.
      fetch_one(0, 0, 32'h0000_006F);
      retire(0, 2'b10, 1'b0, 32'h0000_0102);
      for (int i = 0; i < 10; i++) begin
         instr_ready        = 1'b1;
         bus.imem_req_ready = 1'b1;
         bus.imem_rsp_valid = 1'($urandom);
         tick();
         check("halt_no_req", 32'(bus.imem_req_valid), 32'd0);
         check("halt_valid", 32'(instr_valid), 32'd0);
         check("halt_fault", 32'(fetch_fault), 32'd1);
         check("halt_count", retired_count, model_count);
      end
      instr_ready        = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;

      // Reset out of HALT, advance into WAIT, then reset again mid-wait.
      do_reset();
      fetch_one(0, 0, 32'h0000_0013);
      retire(0, 2'b10, 1'b0, 32'h0000_0200);
      wait_req();
      check("pre_abort_addr", bus.imem_addr, 32'h200);
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      check("in_wait", 32'(bus.imem_req_valid), 32'd0);
      do_reset();
      fetch_one(0, 0, 32'hCAFE_F00D);
      retire(0, 2'b00, 1'b0, 32'h0);
      check("restart_count", retired_count, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Absolute time guard so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout observed=%0d expected=%0d", cyc, 0);
      $fatal(1, "simulation time limit reached");
   end

endmodule
